// File: rtl/noc_param_router.sv
// noc_param_router: 5-port (N/S/E/W/L) XY mesh router with input FIFOs, per-output round-robin arbitration and credit flow control.
// Define NOC_ROUTER_STATS_EN to add the stat_count port with per-output saturating sent-flit counters.
module noc_param_router #(
  parameter logic [3:0] XCOORD     = 4'd0,
  parameter logic [3:0] YCOORD     = 4'd0,
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CREDITS    = 4,
  parameter logic [4:0] PORT_MASK  = 5'b11111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          in_valid,
  input  logic [5*DATA_W-1:0] in_data,
  output logic [4:0]          in_credit,
  output logic [4:0]          out_valid,
  output logic [5*DATA_W-1:0] out_data,
  input  logic [4:0]          out_credit,
  output logic                err_misroute,
  output logic                err_overflow
`ifdef NOC_ROUTER_STATS_EN
  ,
  output logic [5*16-1:0]     stat_count
`endif
);

  localparam int NP    = 5;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W  = $clog2(CREDITS + 1);

  logic [NP-1:0]             head_valid, full, misroute, ovf, pop;
  logic [NP-1:0]             gnt_in, gnt_out, credit_ok;
  logic [NP-1:0][DATA_W-1:0] head_data, out_data_d, out_data_q;
  logic [NP-1:0][NP-1:0]     route_oh, gnt;
  logic [NP-1:0][2:0]        rr_q, rr_d;
  logic [NP-1:0]             out_valid_q, in_credit_q;
  logic                      err_misroute_q, err_overflow_q;

  // X is resolved before Y; a flit addressed to this tile goes to L.
  function automatic logic [4:0] route_fn(input logic [7:0] dst);
    if (dst[7:4] > XCOORD)      route_fn = 5'b00100;
    else if (dst[7:4] < XCOORD) route_fn = 5'b01000;
    else if (dst[3:0] > YCOORD) route_fn = 5'b00001;
    else if (dst[3:0] < YCOORD) route_fn = 5'b00010;
    else                        route_fn = 5'b10000;
  endfunction

  // First existing port after i in cyclic order; L always exists so one is found.
  function automatic logic [2:0] next_port(input int i);
    int j;
    next_port = 3'd4;
    for (int k = NP; k >= 1; k--) begin
      j = (i + k) % NP;
      if (PORT_MASK[j]) next_port = 3'(j);
    end
  endfunction

  for (genvar p = 0; p < NP; p++) begin : g_in
    assign route_oh[p] = route_fn(head_data[p][7:0]);
    assign misroute[p] = head_valid[p] && |(route_oh[p] & ~PORT_MASK);
    assign pop[p]      = misroute[p] | gnt_in[p];

    if (PORT_MASK[p]) begin : g_fifo
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
      logic [CNT_W-1:0]  cnt_q;
      logic              wr_en;

      assign full[p]       = (cnt_q == CNT_W'(FIFO_DEPTH));
      assign wr_en         = in_valid[p] && (!full[p] || pop[p]);
      assign ovf[p]        = in_valid[p] && full[p] && !pop[p];
      assign head_valid[p] = (cnt_q != '0);
      assign head_data[p]  = mem_q[rd_ptr_q];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          if (wr_en)  wr_ptr_q <= wr_ptr_q + 1'b1;
          if (pop[p]) rd_ptr_q <= rd_ptr_q + 1'b1;
          if (wr_en && !pop[p])      cnt_q <= cnt_q + 1'b1;
          else if (!wr_en && pop[p]) cnt_q <= cnt_q - 1'b1;
        end
      end

      // NOTE: flit storage is deliberately not reset; the pointers and count alone define which entries are valid.
      always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data[p*DATA_W +: DATA_W];
      end
    end else begin : g_no_fifo
      assign full[p]       = 1'b0;
      assign ovf[p]        = 1'b0;
      assign head_valid[p] = 1'b0;
      assign head_data[p]  = '0;
    end
  end

  // NOTE: every combinational output gets a default first so no path can leave a latch behind.
  always_comb begin
    logic found;
    int   idx;
    gnt        = '0;
    gnt_in     = '0;
    gnt_out    = '0;
    out_data_d = '0;
    rr_d       = rr_q;
    found      = 1'b0;
    idx        = 0;
    for (int o = 0; o < NP; o++) begin
      found = 1'b0;
      if (PORT_MASK[o] && credit_ok[o]) begin
        for (int k = 0; k < NP; k++) begin
          idx = int'(rr_q[o]) + k;
          if (idx >= NP) idx = idx - NP;
          if (!found && head_valid[idx] && !misroute[idx] && route_oh[idx][o]) begin
            found           = 1'b1;
            gnt[o][idx]     = 1'b1;
            out_data_d[o]   = head_data[idx];
            rr_d[o]         = next_port(idx);
          end
        end
      end
      gnt_out[o] = |gnt[o];
      gnt_in     = gnt_in | gnt[o];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q    <= '0;
      out_data_q     <= '0;
      rr_q           <= '0;
      in_credit_q    <= '0;
      err_misroute_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      out_valid_q    <= gnt_out;
      in_credit_q    <= pop;
      err_misroute_q <= |misroute;
      err_overflow_q <= |ovf;
      for (int o = 0; o < NP; o++) begin
        if (gnt_out[o]) begin
          out_data_q[o] <= out_data_d[o];
          rr_q[o]       <= rr_d[o];
        end
      end
    end
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    if (PORT_MASK[o]) begin : g_credit
      logic [CR_W-1:0] credit_q, credit_d;

      // A send and a returning credit in the same cycle cancel out.
      always_comb begin
        credit_d = credit_q;
        if (gnt_out[o] && !out_credit[o])
          credit_d = credit_q - 1'b1;
        else if (!gnt_out[o] && out_credit[o] && credit_q != CR_W'(CREDITS))
          credit_d = credit_q + 1'b1;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) credit_q <= CR_W'(CREDITS);
        else      credit_q <= credit_d;
      end

      assign credit_ok[o] = (credit_q != '0);
    end else begin : g_no_credit
      assign credit_ok[o] = 1'b0;
    end

`ifdef NOC_ROUTER_STATS_EN
    if (PORT_MASK[o]) begin : g_stat
      logic [15:0] stat_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                stat_q <= '0;
        else if (out_valid_q[o] && stat_q != '1) stat_q <= stat_q + 1'b1;
      end
      assign stat_count[o*16 +: 16] = stat_q;
    end else begin : g_no_stat
      assign stat_count[o*16 +: 16] = '0;
    end
`endif
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign in_credit    = in_credit_q;
  assign err_misroute = err_misroute_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: doc/noc_param_router.md
# noc_param_router

Parametrised 5-port (N/S/E/W/L) mesh router with input buffering, XY dimension-order routing, per-output round-robin arbitration and credit-based flow control. One module covers interior, edge and corner tiles: a port mask compiles absent ports out. Each tile of the mesh instantiates one, with its local port (L) attached to the tile's network interface.

## Interface
- XCOORD, 0: tile X coordinate (4-bit value).
- YCOORD, 0: tile Y coordinate (4-bit value).
- DATA_W, 16: flit width, minimum 8. Destination is X = flit[7:4], Y = flit[3:0].
- FIFO_DEPTH, 4: input FIFO entries per port, power of two, at least 2.
- CREDITS, 4: initial and maximum credit count per output. Equals the downstream FIFO_DEPTH.
- PORT_MASK, 5'b11111: bit p set means port p exists. Port index: 0=N, 1=S, 2=E, 3=W, 4=L. Bit 4 must be 1.

Ports (per-port buses are packed, port p occupies slice [p*W +: W]):
- clk  in  1  router clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  5  flit strobe from upstream, per port.
- in_data  in  5*DATA_W  incoming flits.
- in_credit  out  5  one-cycle pulse per input FIFO pop, returned upstream.
- out_valid  out  5  flit strobe to downstream.
- out_data  out  5*DATA_W  outgoing flits.
- out_credit  in  5  credit-return pulse from downstream.
- err_misroute  out  1  one-cycle pulse when a flit routes to a masked port.
- err_overflow  out  1  one-cycle pulse when a write hits a full input FIFO.
- stat_count  out  5*16  per-output sent-flit counters. Present only with NOC_ROUTER_STATS_EN.

## Operation
- **Input FIFO (per existing port):**
  - in_valid writes in_data.
  - A write to a full FIFO is discarded and pulses err_overflow.
  - The head flit is visible the cycle after it is written.
- **Route computation (combinational on the head flit):**
  - dX > XCOORD → E; dX < XCOORD → W.
  - Otherwise dY > YCOORD → N; dY < YCOORD → S.
  - Otherwise → L.
- **Misroute:** if the computed output is masked off, the head is popped without forwarding. The router pulses err_misroute and in_credit for that port.
- **Arbitration (per output):**
  - Requesters are the inputs whose valid head routes to this output.
  - An output is eligible when its credit count > 0.
  - Round-robin pointer: after a grant to input i, the pointer becomes (i+1) mod 5, skipping masked ports. Reset pointer is 0.
  - Each input holds at most one request, so at most one grant per input per cycle.
- **Grant cycle effects:**
  - The flit is registered into out_data[o].
  - out_valid[o] goes high next cycle.
  - The input FIFO pops, and in_credit[i] pulses next cycle.
  - credit[o] decrements.
- **Credit counter (per output):**
  - out_credit alone: +1, saturating at CREDITS (excess pulses are ignored).
  - Send alone: −1.
  - Send and out_credit in the same cycle: unchanged.
- **Masked ports:**
  - in_valid and out_credit are ignored.
  - out_valid, in_credit and out_data are tied to 0.
  - No FIFO or counter is generated.

## Timing
- Reset (rst low, async) values:
  - All outputs 0.
  - FIFOs empty, credits = CREDITS, RR pointers 0, stat counters 0.
  - Reset mid-packet discards all buffered flits; no credit pulses are issued for them.
- Latency:
  - Flit accepted at edge t is visible at the FIFO head in cycle t+1.
  - Uncontended, it is granted at edge t+1, with out_valid high in cycle t+2 (2 cycles).
  - in_credit pulses in the same cycle as out_valid.
- Throughput: 1 flit/cycle/output. Each losing requester waits at most 4 grants.
- out_valid and in_credit are single-cycle pulses per flit. There is no back-pressure signal; flow control is credits only.
- A write and a pop on a full FIFO in the same cycle are both performed; this is not an overflow.

## Configuration
- NOC_ROUTER_STATS_EN:
  - Defined: stat_count exists. Each 16-bit counter increments on every out_valid of its output and saturates at 16'hFFFF.
  - Undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Reset/idle:
  - Stimulus: XCOORD=1, YCOORD=1, rst low then high.
  - Required: all outputs 0.
  - Required: a flit 16'h00_11 on L exits L at out_valid in cycle t+2, with in_credit[4] pulsing in the same cycle.
- XY routing:
  - Stimulus: flits to (2,1), (0,1), (1,2), (1,0) injected on L.
  - Required: they exit E, W, N, S respectively.
  - Required: flit (2,2) from W exits E, because X is resolved first.
- Round-robin:
  - Stimulus: N, S and W each hold 3 flits for L, injected in the same cycle.
  - Required: L grant order is N, S, W, N, S, W, N, S, W, one per cycle.
- Credits:
  - Stimulus: CREDITS=4, no out_credit, 6 flits to E.
  - Required: exactly 4 flits emerge and 2 stay buffered.
  - Stimulus: one out_credit pulse.
  - Required: the 5th flit is sent 1 cycle later.
  - Stimulus: out_credit concurrent with a send.
  - Required: the count holds.
- Edge mask:
  - Stimulus: PORT_MASK=5'b11101 (no S), flit to (1,0) from L.
  - Required: err_misroute pulses, in_credit[4] pulses, out_valid stays 0.
  - Stimulus: FIFO_DEPTH=4, 5 back-to-back writes with the output blocked.
  - Required: err_overflow on the 5th write.
- Stats (NOC_ROUTER_STATS_EN):
  - Stimulus: 3 flits sent on W.
  - Required: stat_count[W]=3.
  - Stimulus: preload toward saturation.
  - Required: the counter holds at 16'hFFFF.
